// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch-stage state encoding.
package cpu_pkg;
   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] PC_STEP   = 32'd4;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      MISS  = 2'd1,
      HOLD  = 2'd2,
      KILL  = 2'd3
   } fetch_state_e;
endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the I-cache and feeds IF/ID.
//
// state | meaning
// FETCH | request at pc_q, first cycle of this fetch
// MISS  | request at pc_q still outstanding, cache busy
// HOLD  | word fetched but downstream stalled; word parked in r_buf, no request
// KILL  | redirect arrived mid-miss; drain old request, then jump to r_kill_pc
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            hazard_stall_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            icache_req_o,
   output logic [XLEN-1:0] icache_addr_o,
   input  logic            icache_stall_i,
   input  logic [XLEN-1:0] icache_rdata_i,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_plus_o,
   output logic            if_stall_o
);

   fetch_state_e    r_state;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_buf;
   logic [XLEN-1:0] r_kill_pc;

   logic            w_req;
   logic            w_done;
   logic [XLEN-1:0] w_target;
   logic [XLEN-1:0] w_pc_inc;
   logic [XLEN-1:0] w_pc_out;

   assign w_req    = rst_i && (r_state != HOLD);
   assign w_done   = w_req && !icache_stall_i;
   assign w_target = {redirect_pc_i[XLEN-1:2], 2'b00};
   assign w_pc_inc = r_pc + PC_STEP;
   assign w_pc_out = rst_i ? r_pc : RESET_PC;

   assign icache_req_o  = w_req;
   assign icache_addr_o = r_pc;
   assign pc_o          = w_pc_out;
   assign pc_plus_o     = w_pc_out + PC_STEP;

   // A redirect always hands IF/ID a bubble with stall low so the NOP is captured.
   always_comb begin
      instr_o    = NOP_INSTR;
      if_stall_o = 1'b1;
      if (rst_i) begin
         if (redirect_i) begin
            if_stall_o = 1'b0;
         end else begin
            case (r_state)
               FETCH, MISS: begin
                  if (w_done && !hazard_stall_i) begin
                     instr_o    = icache_rdata_i;
                     if_stall_o = 1'b0;
                  end
               end
               HOLD: begin
                  instr_o    = r_buf;
                  if_stall_o = hazard_stall_i;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state   <= FETCH;
         r_pc      <= RESET_PC;
         r_buf     <= NOP_INSTR;
         r_kill_pc <= '0;
      end else if (redirect_i) begin
         // The cache cannot abort an in-flight miss, so remember the target instead.
         if (r_state == KILL) begin
            r_kill_pc <= w_target;
         end else if (r_state == HOLD || w_done) begin
            r_pc    <= w_target;
            r_buf   <= NOP_INSTR;
            r_state <= FETCH;
         end else begin
            r_kill_pc <= w_target;
            r_state   <= KILL;
         end
      end else begin
         case (r_state)
            FETCH, MISS: begin
               if (w_done && !hazard_stall_i) begin
                  r_pc    <= w_pc_inc;
                  r_state <= FETCH;
               end else if (w_done) begin
                  r_buf   <= icache_rdata_i;
                  r_state <= HOLD;
               end else begin
                  r_state <= MISS;
               end
            end
            HOLD: begin
               if (!hazard_stall_i) begin
                  r_pc    <= w_pc_inc;
                  r_state <= FETCH;
               end
            end
            KILL: begin
               if (w_done) begin
                  r_pc    <= r_kill_pc;
                  r_state <= FETCH;
               end
            end
            default: r_state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a transaction-level fetch model.
module tb_fetch_unit;
   import cpu_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        hazard_stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        icache_req_o;
   logic [31:0] icache_addr_o;
   logic        icache_stall_i;
   logic [31:0] icache_rdata_i;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic [31:0] pc_plus_o;
   logic        if_stall_o;

   always #5 clk_i = ~clk_i;

   fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP_INSTR)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .hazard_stall_i (hazard_stall_i),
      .redirect_i     (redirect_i),
      .redirect_pc_i  (redirect_pc_i),
      .icache_req_o   (icache_req_o),
      .icache_addr_o  (icache_addr_o),
      .icache_stall_i (icache_stall_i),
      .icache_rdata_i (icache_rdata_i),
      .instr_o        (instr_o),
      .pc_o           (pc_o),
      .pc_plus_o      (pc_plus_o),
      .if_stall_o     (if_stall_o)
   );

   typedef struct {
      bit          rst;
      bit          hz;
      bit          rd;
      logic [31:0] tgt;
      bit          cs;
      logic [31:0] rdat;
   } stim_t;

   int total = 0;
   int bad   = 0;

   // Model: the PC to fetch, an optional parked word, and an optional pending redirect.
   logic [31:0] m_pc = RST_PC;
   logic [31:0] m_buf = NOP_INSTR;
   logic [31:0] m_kill_tgt = '0;
   bit          m_have = 0;
   bit          m_kill = 0;

   logic        e_req;
   logic [31:0] e_addr, e_instr, e_pc, e_pcp;
   logic        e_stall;

   function automatic logic [129:0] got();
      return {icache_req_o, (rst_i ? icache_addr_o : 32'h0), instr_o, pc_o, pc_plus_o, if_stall_o};
   endfunction

   function automatic logic [129:0] expv();
      return {e_req, e_addr, e_instr, e_pc, e_pcp, e_stall};
   endfunction

   function automatic stim_t mk(bit rst, bit hz, bit rd, logic [31:0] tgt, bit cs);
      stim_t s;
      s.rst = rst; s.hz = hz; s.rd = rd; s.tgt = tgt; s.cs = cs; s.rdat = $urandom;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      logic [31:0] tg;
      bit req, done;
      rst_i = s.rst; hazard_stall_i = s.hz; redirect_i = s.rd;
      redirect_pc_i = s.tgt; icache_stall_i = s.cs; icache_rdata_i = s.rdat;
      assert (!(s.rd && s.hz)) else $error("bench drove redirect together with hazard stall");
      tg = {s.tgt[31:2], 2'b00};
      if (!s.rst) begin
         e_req = 0; e_addr = 0; e_instr = NOP_INSTR; e_pc = RST_PC; e_stall = 1;
         m_pc = RST_PC; m_have = 0; m_kill = 0; m_kill_tgt = 0; m_buf = NOP_INSTR;
      end else begin
         req = !m_have;
         done = req && !s.cs;
         e_req = req; e_addr = m_pc; e_pc = m_pc; e_instr = NOP_INSTR; e_stall = 1;
         if (s.rd) begin
            e_stall = 0;
            if (m_kill) m_kill_tgt = tg;
            else if (m_have || done) begin m_pc = tg; m_have = 0; end
            else begin m_kill = 1; m_kill_tgt = tg; end
         end else if (m_kill) begin
            if (done) begin m_pc = m_kill_tgt; m_kill = 0; end
         end else if (m_have) begin
            e_instr = m_buf; e_stall = s.hz;
            if (!s.hz) begin m_pc = m_pc + 4; m_have = 0; end
         end else if (done && !s.hz) begin
            e_instr = s.rdat; e_stall = 0; m_pc = m_pc + 4;
         end else if (done) begin
            m_have = 1; m_buf = s.rdat;
         end
      end
      e_pcp = e_pc + 32'd4;
      #2;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      stim_t q[$];
      q.push_back(mk(0, 0, 0, 0, 0));
      q.push_back(mk(0, 0, 0, 0, 1));
      foreach (q[i]) begin
         apply(q[i]);
         total++;
         if (got() !== expv()) begin
            bad++;
            $display("FAIL reset cyc%0d got=%h want=%h", i, got(), expv());
         end
         tick();
      end
   endtask

   task automatic test_hits_and_miss();
      stim_t q[$];
      for (int i = 0; i < 4; i++) q.push_back(mk(1, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++) q.push_back(mk(1, 0, 0, 0, 1));
      q.push_back(mk(1, 0, 0, 0, 0));
      q.push_back(mk(1, 0, 0, 0, 0));
      foreach (q[i]) begin
         apply(q[i]);
         total++;
         if (got() !== expv()) begin
            bad++;
            $display("FAIL hit_miss cyc%0d got=%h want=%h", i, got(), expv());
         end
         tick();
      end
      total++;
      if (icache_addr_o !== 32'h18) begin
         bad++;
         $display("FAIL miss_next_addr got=%h want=%h", icache_addr_o, 32'h18);
      end
   endtask

   task automatic test_hold();
      stim_t q[$];
      int reqs = 0;
      for (int i = 0; i < 2; i++) q.push_back(mk(1, 0, 0, 0, 0));
      q.push_back(mk(1, 1, 0, 0, 0));
      q.push_back(mk(1, 1, 0, 0, 0));
      q.push_back(mk(1, 0, 0, 0, 0));
      q.push_back(mk(1, 0, 0, 0, 0));
      foreach (q[i]) begin
         apply(q[i]);
         if (icache_req_o && !icache_stall_i && icache_addr_o == 32'h20) reqs++;
         total++;
         if (got() !== expv()) begin
            bad++;
            $display("FAIL hold cyc%0d got=%h want=%h", i, got(), expv());
         end
         tick();
      end
      total++;
      if (reqs !== 1) begin
         bad++;
         $display("FAIL hold_req_count got=%0d want=1", reqs);
      end
   endtask

   task automatic test_redirect();
      stim_t q[$];
      q.push_back(mk(1, 0, 1, 32'h103, 0));
      q.push_back(mk(1, 0, 1, 32'h40, 0));
      q.push_back(mk(1, 0, 0, 0, 1));
      q.push_back(mk(1, 0, 1, 32'h200, 1));
      q.push_back(mk(1, 0, 0, 0, 1));
      q.push_back(mk(1, 0, 0, 0, 0));
      q.push_back(mk(1, 0, 0, 0, 0));
      foreach (q[i]) begin
         apply(q[i]);
         total++;
         if (got() !== expv()) begin
            bad++;
            $display("FAIL redirect cyc%0d got=%h want=%h", i, got(), expv());
         end
         tick();
      end
      total++;
      if (icache_addr_o !== 32'h204) begin
         bad++;
         $display("FAIL redirect_final_addr got=%h want=%h", icache_addr_o, 32'h204);
      end
   endtask

   task automatic test_reset_mid_miss();
      stim_t q[$];
      q.push_back(mk(1, 0, 0, 0, 1));
      q.push_back(mk(1, 0, 0, 0, 1));
      q.push_back(mk(0, 0, 0, 0, 1));
      q.push_back(mk(0, 0, 0, 0, 0));
      q.push_back(mk(1, 0, 0, 0, 1));
      q.push_back(mk(1, 0, 0, 0, 0));
      q.push_back(mk(1, 0, 0, 0, 0));
      foreach (q[i]) begin
         apply(q[i]);
         total++;
         if (got() !== expv()) begin
            bad++;
            $display("FAIL reset_mid_miss cyc%0d got=%h want=%h", i, got(), expv());
         end
         tick();
      end
   endtask

   task automatic test_wrap();
      stim_t q[$];
      q.push_back(mk(1, 0, 1, 32'hFFFF_FFFE, 0));
      q.push_back(mk(1, 0, 0, 0, 0));
      q.push_back(mk(1, 0, 0, 0, 0));
      foreach (q[i]) begin
         apply(q[i]);
         total++;
         if (got() !== expv()) begin
            bad++;
            $display("FAIL wrap cyc%0d got=%h want=%h", i, got(), expv());
         end
         tick();
      end
   endtask

   task automatic test_random();
      stim_t s;
      for (int i = 0; i < 3000; i++) begin
         s = mk(($urandom_range(99) != 0), ($urandom_range(3) == 0), 0,
                $urandom, ($urandom_range(9) < 3));
         if (!s.hz) s.rd = ($urandom_range(6) == 0);
         apply(s);
         total++;
         if (got() !== expv()) begin
            bad++;
            $display("FAIL random cyc%0d got=%h want=%h", i, got(), expv());
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_hits_and_miss();
      test_hold();
      test_redirect();
      test_reset_mid_miss();
      test_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage. It owns the PC, issues requests to the instruction cache and produces the instr/pc/pc_plus/stall values consumed by the IF/ID pipeline register. It absorbs I-cache miss latency, back-pressure from downstream hazards, and branch/jump redirects from ID. On a redirect or a bubble it inserts a NOP.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-low
hazard_stall_i  in  1  downstream stall (load-use, D-cache); hold the current fetch
redirect_i  in  1  taken branch/jump resolved in ID
redirect_pc_i  in  32  redirect target
icache_req_o  out  1  fetch request
icache_addr_o  out  32  fetch address (= pc_q)
icache_stall_i  in  1  cache busy/miss; rdata is valid in a cycle with req=1 and stall=0
icache_rdata_i  in  32  fetched instruction
instr_o  out  32  to IF/ID instr_i
pc_o  out  32  PC of instr_o, to IF/ID pc_i
pc_plus_o  out  32  pc_o+4, to IF/ID pc_plus_i
if_stall_o  out  1  to IF/ID Stall_i

Behaviour:
- Registers:
  - pc_q, reset RESET_PC
  - state, reset FETCH
  - buf_q (instr), reset NOP_INSTR
  - kill_pc_q, reset 0
- Reset: all registers reset on posedge while rst_i=0. While rst_i=0: icache_req_o=0, instr_o=NOP_INSTR, pc_o=RESET_PC, if_stall_o=1.
- done = icache_req_o & ~icache_stall_i. Outputs are combinational from state and inputs; IF/ID provides the pipeline register.
- pc_o = pc_q in every state. pc_plus_o = pc_o+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Redirect targets have bit[1:0] forced to 0.
- FETCH (req=1):
  - done & ~hazard_stall_i: instr_o=rdata, if_stall_o=0, pc_q<=pc_q+4.
  - done & hazard_stall_i: buf_q<=rdata, ->HOLD, if_stall_o=1.
  - ~done: ->MISS, instr_o=NOP, if_stall_o=1.
- MISS (req=1, addr held): same completion rules as FETCH; stays in MISS while ~done.
- HOLD (req=0):
  - instr_o=buf_q, if_stall_o=hazard_stall_i.
  - On ~hazard_stall_i: pc_q<=pc_q+4, ->FETCH. Completed data is never re-fetched.
- KILL (req=1 on the old address; the cache cannot abort):
  - instr_o=NOP, if_stall_o=1.
  - On done: discard rdata, pc_q<=kill_pc_q, ->FETCH.
- Redirect has priority over all of the above. In the redirect cycle: instr_o=NOP, if_stall_o=0, so IF/ID captures a bubble.
  - If state is HOLD, or FETCH/MISS with done: pc_q<=target, ->FETCH, buf_q discarded.
  - If state is FETCH/MISS with ~done: kill_pc_q<=target, ->KILL.
  - Redirect in KILL: kill_pc_q<=newest target, state stays KILL.
- Precondition: redirect_i is never high together with hazard_stall_i. The bench asserts this; behaviour is undefined if violated.
- Combinational path icache_stall_i -> if_stall_o is permitted.
- Steady-state throughput: 1 instruction/cycle on hits.

Decomposition:
- Shared package (cpu_pkg): NOP_INSTR constant, PC_STEP=4, fetch state enum {FETCH, MISS, HOLD, KILL}, XLEN=32.
- Single module, no sub-module. The next-PC mux and the FSM are small enough to keep inline.

Test Plan:
1. Reset, then 4 hits with no stalls: addr 0,4,8,C on consecutive cycles; instr_o equals rdata each cycle; if_stall_o=0; pc_plus_o=pc_o+4.
2. Miss of 3 cycles at pc=0x10: if_stall_o=1 and instr_o=NOP for 3 cycles. Data is delivered in the 4th cycle; the next addr is 0x14.
3. Hit at 0x20 with hazard_stall_i=1 for 2 cycles: no request in the HOLD cycles; then instr_o=buffered word, pc_o=0x20, next addr 0x24; exactly one request for 0x20.
4. Redirect to 0x103 on a hit cycle: IF/ID gets NOP that cycle; next addr is 0x100.
5. Redirect to 0x200 during a miss at 0x40 lasting 2 more cycles: addr stays 0x40 until done; data is discarded; then addr 0x200; instr_o=NOP throughout.
6. Reset asserted mid-MISS: req drops to 0 immediately. After release, fetch restarts at RESET_PC with instr_o=NOP until the first completion.
7. PC wrap at 32'hFFFF_FFFC: pc_plus_o=0 and next addr 0.
